counter_mod_n_down: RTL and testbench

Parameterised modulo-N down counter, the decrementing counterpart of the team's mod-6 up counter. It counts MOD-1, MOD-2, …, 0, then wraps back to MOD-1. It supports count-enable, synchronous load and a cascade borrow, so several instances can chain into multi-digit down-timers. It sits in the SEQUENTIAL/COUNTER library and feeds timers, dividers and countdown display logic.

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_mod_n_down.sv | 64 ++++++
 tb/tb_counter_mod_n_down.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the SEQUENTIAL/COUNTER library (up and down counters).
package counter_pkg;

    localparam int COUNTER_MOD_DEFAULT = 6;

    // Minimum register width able to hold codes 0..mod-1, never below one bit.
    function automatic int counter_width(input int mod);
        if (mod <= 2) begin
            return 1;
        end
        return $clog2(mod);
    endfunction

endpackage

// File: rtl/counter_mod_n_down.sv
// Modulo-MOD down counter with enable/borrow cascade and a one-cycle wrap pulse.
// Optional synchronous load is compiled in with `define DOWN_COUNTER_LOAD_EN.
module counter_mod_n_down
    import counter_pkg::*;
#(
    parameter int MOD   = COUNTER_MOD_DEFAULT,
    parameter int WIDTH = counter_width(MOD)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
`ifdef DOWN_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] dout,
    output logic             borrow_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] r_dout;
    logic             r_wrap;
    logic             w_at_zero;

    assign w_at_zero  = (r_dout == '0);
    // dout is MOD-1 throughout reset, so borrow_out is low then regardless of en.
    assign borrow_out = en && w_at_zero;
    assign dout       = r_dout;
    assign wrap       = r_wrap;

`ifdef DOWN_COUNTER_LOAD_EN
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] w_load_sat;

    // Out-of-range load values saturate to MOD-1 so no illegal code is ever held.
    assign w_load_sat = ({1'b0, load_val} < MOD_EXT) ? load_val : TOP_VAL;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout <= TOP_VAL;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
`ifdef DOWN_COUNTER_LOAD_EN
            if (load) begin
                r_dout <= w_load_sat;
            end else
`endif
            if (en) begin
                if (w_at_zero) begin
                    r_dout <= TOP_VAL;
                    r_wrap <= 1'b1;
                end else begin
                    r_dout <= r_dout - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_mod_n_down.sv
// Scoreboard bench for counter_mod_n_down (MOD=6), plus a 10x6 two-digit cascade.
module tb_counter_mod_n_down;
    import counter_pkg::*;

`ifdef DOWN_COUNTER_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic [2:0] dout;
    logic       borrow_out;
    logic       wrap;
`ifdef DOWN_COUNTER_LOAD_EN
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;
`endif

    logic       c_en = 1'b0;
    logic [3:0] lo_dout;
    logic [2:0] hi_dout;
    logic       lo_borrow, hi_borrow, lo_wrap, hi_wrap;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] m_dout;
    logic       m_wrap;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    counter_mod_n_down #(.MOD(6), .WIDTH(3)) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
`ifdef DOWN_COUNTER_LOAD_EN
        .load(load), .load_val(load_val),
`endif
        .dout(dout), .borrow_out(borrow_out), .wrap(wrap)
    );

    counter_mod_n_down #(.MOD(10), .WIDTH(4)) u_lo (
        .clk(clk), .reset_n(reset_n), .en(c_en),
`ifdef DOWN_COUNTER_LOAD_EN
        .load(1'b0), .load_val(4'd0),
`endif
        .dout(lo_dout), .borrow_out(lo_borrow), .wrap(lo_wrap)
    );

    counter_mod_n_down #(.MOD(6), .WIDTH(3)) u_hi (
        .clk(clk), .reset_n(reset_n), .en(lo_borrow),
`ifdef DOWN_COUNTER_LOAD_EN
        .load(1'b0), .load_val(3'd0),
`endif
        .dout(hi_dout), .borrow_out(hi_borrow), .wrap(hi_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called just after a rising edge: drive inputs, check borrow, push the model's next state,
    // then pop and compare once the DUT has taken the edge.
    task automatic drive(input logic e, input logic ld, input logic [2:0] lv);
        logic [3:0] got;
        en = e;
`ifdef DOWN_COUNTER_LOAD_EN
        load = ld;
        load_val = lv;
`endif
        #1;
        chk("borrow_out", borrow_out, e && (m_dout == 3'd0));
        if (LOAD_EN && ld) begin
            m_dout = (lv < 3'd6) ? lv : 3'd5;
            m_wrap = 1'b0;
        end else if (e && m_dout == 3'd0) begin
            m_dout = 3'd5;
            m_wrap = 1'b1;
        end else if (e) begin
            m_dout = m_dout - 3'd1;
            m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
        end
        exp_q.push_back({m_wrap, m_dout});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 1, 0);
        end else begin
            got = exp_q.pop_front();
            chk("dout", dout, got[2:0]);
            chk("wrap", wrap, got[3]);
        end
    endtask

    initial begin
        int hi_wraps;
        int guard;

        // Reset held two cycles with en high: en must be ignored.
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout, 5);
        chk("rst_wrap", wrap, 0);
        chk("rst_borrow", borrow_out, 0);
        reset_n = 1'b1;
        en = 1'b0;
        m_dout = 3'd5;
        m_wrap = 1'b0;

        // Full count and wrap: 4 3 2 1 0 5.
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 3'd0);
        drive(1'b1, 1'b0, 3'd0);
        drive(1'b1, 1'b0, 3'd0);
        chk("at_three", dout, 3);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 3'd0);

        if (LOAD_EN) begin
            drive(1'b0, 1'b1, 3'd2);
            drive(1'b1, 1'b0, 3'd0);
            drive(1'b1, 1'b0, 3'd0);
            drive(1'b1, 1'b1, 3'd4);
            drive(1'b0, 1'b1, 3'd7);
            drive(1'b0, 1'b1, 3'd6);
        end

        guard = 0;
        while (m_dout != 3'd2 && guard < 20) begin
            drive(1'b1, 1'b0, 3'd0);
            guard++;
        end
        chk("reach_two", dout, 2);

        // Asynchronous reset between edges.
        en = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_dout", dout, 5);
        chk("async_wrap", wrap, 0);
        #1;
        reset_n = 1'b1;
        m_dout = 3'd5;
        m_wrap = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 3'd0);
        drive(1'b1, 1'b0, 3'd0);

        // Two-digit cascade: 60 enabled cycles bring (lo, hi) back to (9, 5).
        chk("casc_lo_init", lo_dout, 9);
        chk("casc_hi_init", hi_dout, 5);
        hi_wraps = 0;
        c_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (hi_wrap) hi_wraps++;
            if (i == 9) begin
                chk("casc_lo_10", lo_dout, 9);
                chk("casc_hi_10", hi_dout, 4);
            end
        end
        c_en = 1'b0;
        chk("casc_lo_end", lo_dout, 9);
        chk("casc_hi_end", hi_dout, 5);
        chk("casc_hi_wraps", hi_wraps, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
